// File: rtl/inst_encoder32_if.sv
// Request/response bundle for inst_encoder32: operand fields in, encoded words out.
// master = request producer and word consumer, slave = the encoder.
interface inst_encoder32_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [5:0]       itype;
  logic [9:0]       fun;
  logic [WIDTH-1:0] d0imm;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      inst;
  logic             err;
  logic             err_clr;
  logic [15:0]      emit_cnt;

  modport master (
    output in_valid, opcode, itype, fun, d0imm, s1, s2imm, out_ready, err_clr,
    input  in_ready, out_valid, inst, err, emit_cnt
  );

  modport slave (
    input  in_valid, opcode, itype, fun, d0imm, s1, s2imm, out_ready, err_clr,
    output in_ready, out_valid, inst, err, emit_cnt
  );
endinterface

// File: rtl/inst_encoder32.sv
// RV32 R/I/S/B/U/J word encoder into a 2-entry FIFO, 1-cycle latency; in_ready = not full (registered only).
// Illegal requests are dropped and set sticky err; INST_ENCODER32_RANGE_CHECK_EN adds field range checks.
module inst_encoder32 #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  inst_encoder32_if.slave bus
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I0  = 7'b0010011;
  localparam logic [6:0] OP_I1  = 7'b0000011;
  localparam logic [6:0] OP_I2  = 7'b1100111;
  localparam logic [6:0] OP_I3  = 7'b1110011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_U0  = 7'b0110111;
  localparam logic [6:0] OP_U1  = 7'b0010111;
  localparam logic [6:0] OP_J   = 7'b1101111;

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic        err_q, err_d;
  logic [15:0] emit_q, emit_d;

  logic [31:0] word;
  logic        op_ok, range_ok, legal, in_rdy, accept, push, pop;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd, rs1, rs2;
  logic        unused_hi;

  assign f3  = bus.fun[9:7];
  assign f7  = bus.fun[6:0];
  assign rd  = bus.d0imm[4:0];
  assign rs1 = bus.s1[4:0];
  assign rs2 = bus.s2imm[4:0];
  assign unused_hi = ^{bus.d0imm, bus.s1, bus.s2imm};

  // Matching exact one-hot patterns rejects zero or multi-bit itype for free.
  always_comb begin
    op_ok = 1'b0;
    word  = '0;
    case (bus.itype)
      6'b100000: begin
        op_ok = (bus.opcode == OP_R);
        word  = {f7, rs2, rs1, f3, rd, bus.opcode};
      end
      6'b010000: begin
        op_ok = bus.opcode inside {OP_I0, OP_I1, OP_I2, OP_I3};
        word  = {bus.s2imm[11:0], rs1, f3, rd, bus.opcode};
      end
      6'b001000: begin
        op_ok = (bus.opcode == OP_S);
        word  = {bus.d0imm[11:5], rs2, rs1, f3, bus.d0imm[4:0], bus.opcode};
      end
      6'b000100: begin
        op_ok = (bus.opcode == OP_B);
        word  = {bus.d0imm[12], bus.d0imm[10:5], rs2, rs1, f3,
                 bus.d0imm[4:1], bus.d0imm[11], bus.opcode};
      end
      6'b000010: begin
        op_ok = bus.opcode inside {OP_U0, OP_U1};
        word  = {bus.s2imm[31:12], rd, bus.opcode};
      end
      6'b000001: begin
        op_ok = (bus.opcode == OP_J);
        word  = {bus.s2imm[20], bus.s2imm[10:1], bus.s2imm[11],
                 bus.s2imm[19:12], rd, bus.opcode};
      end
      default: begin
        op_ok = 1'b0;
        word  = '0;
      end
    endcase
  end

`ifdef INST_ENCODER32_RANGE_CHECK_EN
  // True when v is the sign extension of its low n bits.
  function automatic logic fits_s(input logic [WIDTH-1:0] v, input int unsigned n);
    logic signed [WIDTH-1:0] t;
    t = $signed(v) >>> (n - 1);
    return (t == '0) || (t == '1);
  endfunction

  function automatic logic reg_ok(input logic [WIDTH-1:0] v);
    return (v >> 5) == '0;
  endfunction

  always_comb begin
    range_ok = 1'b1;
    case (bus.itype)
      6'b100000: range_ok = reg_ok(bus.d0imm) & reg_ok(bus.s1) & reg_ok(bus.s2imm);
      6'b010000: range_ok = reg_ok(bus.d0imm) & reg_ok(bus.s1) & fits_s(bus.s2imm, 12);
      6'b001000: range_ok = reg_ok(bus.s1) & reg_ok(bus.s2imm) & fits_s(bus.d0imm, 12);
      6'b000100: range_ok = reg_ok(bus.s1) & reg_ok(bus.s2imm) & fits_s(bus.d0imm, 13)
                            & ~bus.d0imm[0];
      6'b000010: range_ok = reg_ok(bus.d0imm) & (bus.s2imm[11:0] == 12'd0);
      6'b000001: range_ok = reg_ok(bus.d0imm) & fits_s(bus.s2imm, 21) & ~bus.s2imm[0];
      default:   range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

  assign legal  = op_ok & range_ok;
  assign in_rdy = (cnt_q != 2'd2);
  assign accept = bus.in_valid & in_rdy;
  assign push   = accept & legal;
  assign pop    = (cnt_q != 2'd0) & bus.out_ready;

  // Shift FIFO: slot0 is always the head, so inst needs no read mux.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (pop) begin
      slot0_d = slot1_q;
    end
    if (push) begin
      if ((cnt_q == 2'd0) || pop) begin
        slot0_d = word;
      end else begin
        slot1_d = word;
      end
    end
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    emit_d = emit_q + {15'd0, pop};
    err_d  = err_q & ~bus.err_clr;
    if (accept & ~legal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
      err_q   <= 1'b0;
      emit_q  <= 16'd0;
    end else begin
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      err_q   <= err_d;
      emit_q  <= emit_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.inst      = slot0_q;
  assign bus.err       = err_q;
  assign bus.emit_cnt  = emit_q;
endmodule

// File: tb/tb_inst_encoder32.sv
// Scoreboard bench for inst_encoder32: directed vectors plus random requests against a field-level model.
module tb_inst_encoder32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_encoder32_if #(.WIDTH(32)) bus ();
  inst_encoder32 #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] expq[$];
  logic [15:0] exp_emit = 16'd0;
  bit          exp_err  = 1'b0;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    longint unsigned x, m;
    x = 64'(v);
    m = (64'd1 << (hi - lo + 1)) - 64'd1;
    return 32'((x >> lo) & m);
  endfunction

  function automatic bit fits(input logic [31:0] v, input int n);
    longint sv, lim;
    sv  = longint'($signed(v));
    lim = longint'(1) << (n - 1);
    return (sv >= -lim) && (sv < lim);
  endfunction

  // Reference: legality and word layout straight from the instruction-format tables.
  function automatic void ref_encode(input logic [5:0] it, input logic [6:0] op, input logic [9:0] f,
                                     input logic [31:0] d0, input logic [31:0] a, input logic [31:0] b,
                                     output bit legal, output logic [31:0] w);
    logic [31:0] o, f3, f7, rd, r1, r2;
    o  = 32'(op);
    f3 = fld(32'(f), 9, 7);
    f7 = fld(32'(f), 6, 0);
    rd = d0 % 32;
    r1 = a % 32;
    r2 = b % 32;
    legal = 1'b0;
    w = 32'd0;
    if ($countones(it) == 1) begin
      if (it[5]) begin
        legal = (op == 7'b0110011);
        w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | o;
`ifdef INST_ENCODER32_RANGE_CHECK_EN
        legal = legal && d0 < 32 && a < 32 && b < 32;
`endif
      end else if (it[4]) begin
        legal = op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011};
        w = (fld(b, 11, 0) << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | o;
`ifdef INST_ENCODER32_RANGE_CHECK_EN
        legal = legal && d0 < 32 && a < 32 && fits(b, 12);
`endif
      end else if (it[3]) begin
        legal = (op == 7'b0100011);
        w = (fld(d0, 11, 5) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (fld(d0, 4, 0) << 7) | o;
`ifdef INST_ENCODER32_RANGE_CHECK_EN
        legal = legal && a < 32 && b < 32 && fits(d0, 12);
`endif
      end else if (it[2]) begin
        legal = (op == 7'b1100011);
        w = (fld(d0, 12, 12) << 31) | (fld(d0, 10, 5) << 25) | (r2 << 20) | (r1 << 15) |
            (f3 << 12) | (fld(d0, 4, 1) << 8) | (fld(d0, 11, 11) << 7) | o;
`ifdef INST_ENCODER32_RANGE_CHECK_EN
        legal = legal && a < 32 && b < 32 && fits(d0, 13) && (d0 % 2 == 0);
`endif
      end else if (it[1]) begin
        legal = op inside {7'b0110111, 7'b0010111};
        w = (fld(b, 31, 12) << 12) | (rd << 7) | o;
`ifdef INST_ENCODER32_RANGE_CHECK_EN
        legal = legal && d0 < 32 && (b % 4096 == 0);
`endif
      end else begin
        legal = (op == 7'b1101111);
        w = (fld(b, 20, 20) << 31) | (fld(b, 10, 1) << 21) | (fld(b, 11, 11) << 20) |
            (fld(b, 19, 12) << 12) | (rd << 7) | o;
`ifdef INST_ENCODER32_RANGE_CHECK_EN
        legal = legal && d0 < 32 && fits(b, 21) && (b % 2 == 0);
`endif
      end
    end
  endfunction

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      5: return 7'b0110011;
      4: case ($urandom_range(0, 3))
           0: return 7'b0010011;
           1: return 7'b0000011;
           2: return 7'b1100111;
           default: return 7'b1110011;
         endcase
      3: return 7'b0100011;
      2: return 7'b1100011;
      1: return ($urandom_range(0, 1) == 0) ? 7'b0110111 : 7'b0010111;
      default: return 7'b1101111;
    endcase
  endfunction

  // Holds the request until accepted; the model's answer is queued at the accepting edge.
  task automatic send(input logic [5:0] it, input logic [6:0] op, input logic [9:0] f,
                      input logic [31:0] d0, input logic [31:0] a, input logic [31:0] b,
                      input bit use_const, input logic [31:0] cword);
    bit legal;
    logic [31:0] w;
    int t;
    bit ok;
    ref_encode(it, op, f, d0, a, b, legal, w);
    bus.in_valid = 1'b1;
    bus.itype = it;
    bus.opcode = op;
    bus.fun = f;
    bus.d0imm = d0;
    bus.s1 = a;
    bus.s2imm = b;
    t = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      t++;
    end
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
    end else begin
      chk("err_flag", bus.err, exp_err);
      if (legal) expq.push_back(use_const ? cword : w);
      else exp_err = 1'b1;
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((bus.out_valid || expq.size() != 0) && t < 500);
    chk("drain_left", expq.size(), 0);
    tick();
  endtask

  // Monitor: pops the scoreboard on every output handshake and tracks emit_cnt.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_emit = 16'd0;
      end else begin
        chk("emit_cnt", bus.emit_cnt, exp_emit);
        if (bus.out_valid && bus.out_ready) begin
          if (expq.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_out: inst %h with nothing expected", bus.inst);
          end else begin
            e = expq.pop_front();
            chk("inst", bus.inst, e);
          end
          exp_emit++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nb;
    logic [5:0] it;
    logic [6:0] op;
    logic [31:0] rd, ra, rb, imm, d0, b;

    bus.in_valid = 1'b0;
    bus.opcode = '0;
    bus.itype = '0;
    bus.fun = '0;
    bus.d0imm = '0;
    bus.s1 = '0;
    bus.s2imm = '0;
    bus.out_ready = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_inst", bus.inst, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_emit", bus.emit_cnt, 0);
    tick();

    // Full FIFO backpressure with a third request stalled.
    send(6'b100000, 7'b0110011, 10'd0, 32'd3, 32'd1, 32'd2, 1'b1, 32'h002081B3);
    send(6'b010000, 7'b0010011, 10'd0, 32'd1, 32'd2, 32'd5, 1'b1, 32'h00510093);
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    tick();
    fork
      send(6'b000010, 7'b0110111, 10'd0, 32'd5, 32'd0, 32'h12345000, 1'b1, 32'h123452B7);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("hold_inst", bus.inst, 32'h002081B3);
          chk("hold_in_ready", bus.in_ready, 0);
        end
        tick();
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("emit_after_three", bus.emit_cnt, 3);

    // One-cycle latency from empty, then the reference vectors.
    send(6'b100000, 7'b0110011, 10'd0, 32'd3, 32'd1, 32'd2, 1'b1, 32'h002081B3);
    @(negedge clk);
    chk("latency_valid", bus.out_valid, 1);
    chk("latency_inst", bus.inst, 32'h002081B3);
    tick();
    send(6'b010000, 7'b0010011, 10'd0, 32'd1, 32'd2, 32'd5, 1'b1, 32'h00510093);
    send(6'b000010, 7'b0110111, 10'd0, 32'd5, 32'd0, 32'h12345000, 1'b1, 32'h123452B7);
    send(6'b000100, 7'b1100011, 10'd0, 32'hFFFFFFFC, 32'd0, 32'd0, 1'b1, 32'hFE000EE3);
    send(6'b000001, 7'b1101111, 10'd0, 32'd1, 32'd0, 32'd8, 1'b1, 32'h008000EF);
    drain();

    // Illegal type, error clear, set-wins-over-clear, range-checked immediate.
    send(6'b110000, 7'b0110011, 10'd0, 32'd1, 32'd1, 32'd1, 1'b0, 32'd0);
    @(negedge clk);
    chk("illegal_no_out", bus.out_valid, 0);
    chk("illegal_err", bus.err, 1);
    tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("err_cleared", bus.err, 0);
    tick();
    bus.err_clr = 1'b1;
    send(6'b000000, 7'b0110011, 10'd0, 32'd1, 32'd1, 32'd1, 1'b0, 32'd0);
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk("err_set_wins", bus.err, 1);
    tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    exp_err = 1'b0;
    send(6'b010000, 7'b0010011, 10'd0, 32'd1, 32'd0, 32'h00000800, 1'b1, 32'h80000093);
    @(negedge clk);
`ifdef INST_ENCODER32_RANGE_CHECK_EN
    chk("imm800_err", bus.err, 1);
`else
    chk("imm800_err", bus.err, 0);
`endif
    tick();
    drain();

    // Random requests with random consumer stalls.
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 5);
      it = 6'b000001 << k;
      op = pick_op(k);
      if ($urandom_range(0, 9) == 0) it = 6'($urandom);
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      rd = $urandom_range(0, 31);
      ra = $urandom_range(0, 31);
      rb = $urandom_range(0, 31);
      if ($urandom_range(0, 11) == 0) rd = $urandom;
      if ($urandom_range(0, 11) == 0) ra = $urandom;
      imm = $urandom;
      nb = (k == 4 || k == 3) ? 12 : (k == 2) ? 13 : (k == 0) ? 21 : 32;
      if ($urandom_range(0, 3) != 0) begin
        if (nb < 32) imm = 32'($signed(imm << (32 - nb)) >>> (32 - nb));
        if (k == 2 || k == 0) imm[0] = 1'b0;
        if (k == 1) imm[11:0] = 12'd0;
      end
      d0 = (k == 3 || k == 2) ? imm : rd;
      b  = (k == 5 || k == 3 || k == 2) ? rb : imm;
      send(it, op, 10'($urandom), d0, ra, b, 1'b0, 32'd0);
    end
    drain();

    // Reset with two words queued; requests during reset are ignored.
    bus.out_ready = 1'b0;
    send(6'b110000, 7'b0110011, 10'd0, 32'd1, 32'd1, 32'd1, 1'b0, 32'd0);
    send(6'b100000, 7'b0110011, 10'd0, 32'd3, 32'd1, 32'd2, 1'b1, 32'h002081B3);
    send(6'b010000, 7'b0010011, 10'd0, 32'd1, 32'd2, 32'd5, 1'b1, 32'h00510093);
    rst = 1'b1;
    expq.delete();
    bus.in_valid = 1'b1;
    bus.itype = 6'b110000;
    tick();
    bus.itype = 6'b100000;
    bus.opcode = 7'b0110011;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", bus.out_valid, 0);
    chk("rst2_emit", bus.emit_cnt, 0);
    chk("rst2_err", bus.err, 0);
    chk("rst2_in_ready", bus.in_ready, 1);
    chk("rst2_inst", bus.inst, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/inst_encoder32.md
INST_ENCODER32 -- requirements
Module: inst_encoder32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the width of operand/immediate inputs.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  encode request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid & in_ready at clock edge.
REQ-006 SHALL have port opcode  input  7  RV32 opcode placed in inst[6:0].
REQ-007 SHALL have port itype  input  6  one-hot type, bit5..0 = R I S B U J.
REQ-008 SHALL have port fun  input  10  {funct3, funct7}; funct7 used only for R.
REQ-009 SHALL have port d0imm  input  WIDTH  rd address, or imm for S/B.
REQ-010 SHALL have port s1  input  WIDTH  rs1 address.
REQ-011 SHALL have port s2imm  input  WIDTH  rs2 address (R/S/B), or imm for I/U/J.
REQ-012 SHALL have port out_valid  output  1  encoded word available.
REQ-013 SHALL have port out_ready  input  1  consumer takes word when out_valid & out_ready.
REQ-014 SHALL have port inst  output  32  encoded instruction at head of queue.
REQ-015 SHALL have port err  output  1  sticky illegal-request flag.
REQ-016 SHALL have port err_clr  input  1  clears err.
REQ-017 SHALL have port emit_cnt  output  16  count of words delivered.

Function
REQ-018 Encoding SHALL be: R {funct7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; register fields take bits [4:0] of their inputs.
REQ-019 Request SHALL be illegal if itype is not exactly one-hot, or opcode is not a member of the group for that type (R 0110011; I 0010011/0000011/1100111/1110011; S 0100011; B 1100011; U 0110111/0010111; J 1101111).
REQ-020 Accepted legal request SHALL be encoded and pushed into a 2-entry FIFO in the same edge; accepted illegal request SHALL be dropped and set err.
REQ-021 Latency SHALL be 1 cycle: word accepted at edge N visible on inst with out_valid=1 after edge N when FIFO was empty.
REQ-022 in_ready SHALL equal (FIFO occupancy < 2), from registered state only; no combinational path from out_ready to in_ready.
REQ-023 Simultaneous push and pop at occupancy 1 SHALL keep occupancy 1 with ordering preserved; at occupancy 2 push is impossible, pop reduces to 1.
REQ-024 out_valid SHALL equal (occupancy > 0); inst SHALL hold stable while out_valid & ~out_ready.
REQ-025 emit_cnt SHALL increment by 1 on each out handshake, wrapping 0xFFFF -> 0x0000.
REQ-026 err SHALL set on illegal accept, clear on err_clr; simultaneous set and clear SHALL leave err=1.

Reset
REQ-027 On rst=1 at an edge: occupancy 0, out_valid 0, in_ready 1 (next cycle), inst 0, err 0, emit_cnt 0; any in-flight word is discarded.
REQ-028 While rst=1, in_valid SHALL be ignored (no accept, no err).

Configuration
REQ-029 Macro INST_ENCODER32_RANGE_CHECK_EN SHALL, when defined, add range checks to REQ-019: register inputs > 31; I/S imm not sign-extension of 12 bits; B imm not sign-extension of 13 bits or bit0=1; J imm not sign-extension of 21 bits or bit0=1; U imm[11:0] != 0 -- each illegal.
REQ-030 Without the macro, out-of-range fields SHALL be silently truncated per REQ-018 and only REQ-019 checks apply.

Verification
REQ-031 R, op 0110011, fun 0, d0imm 3, s1 1, s2imm 2 -> inst 0x002081B3 one cycle later.
REQ-032 I, op 0010011, d0imm 1, s1 2, s2imm 5 -> 0x00510093; U op 0110111, d0imm 5, s2imm 0x12345000 -> 0x123452B7.
REQ-033 B, op 1100011, d0imm 0xFFFFFFFC, s1 0, s2imm 0 -> 0xFE000EE3; J op 1101111, d0imm 1, s2imm 8 -> 0x008000EF.
REQ-034 out_ready=0, push 3 legal words -> in_ready=0 after second; third held; release out_ready -> 3 words in order, emit_cnt=3.
REQ-035 itype 0b110000 -> no output, err=1; err_clr -> err=0; I imm 0x800, rd1, rs1 0 -> macro defined: dropped, err=1; macro undefined: 0x80000093.
REQ-036 rst asserted with 2 words queued -> out_valid 0, emit_cnt 0, err 0 next cycle.
